// File: rtl/lightbike_pkg.sv
// Shared direction and FSM state encodings for the lightbike engine.
package lightbike_pkg;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirRight = 2'd1,
    DirDown  = 2'd2,
    DirLeft  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StClear     = 3'd1,
    StDriving   = 3'd2,
    StCollision = 3'd3,
    StDone      = 3'd4
  } state_e;

  // Opposite headings differ only in bit 1.
  function automatic logic is_reversal(input logic [1:0] req, input logic [1:0] heading);
    return (req ^ heading) == 2'd2;
  endfunction

endpackage

// File: rtl/lightbike_tick_gen.sv
// Move-tick divider: counts only while enabled, pulses on the last count and wraps.
module lightbike_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count_q;

  assign tick = enable && (count_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (!enable || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/lightbike_engine.sv
// Multi-player lightbike game: occupancy grid, per-tick movement and crash
// resolution, round scoring and a pixel-side registered cell lookup.
module lightbike_engine
  import lightbike_pkg::*;
#(
  parameter int unsigned GRID_W      = 16,
  parameter int unsigned GRID_H      = 16,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned WIN_SCORE   = 3,
  localparam int unsigned XW         = $clog2(GRID_W),
  localparam int unsigned YW         = $clog2(GRID_H)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_PLAYERS-1:0]     dir_valid,
  input  logic [2*NUM_PLAYERS-1:0]   dir,
  input  logic [XW-1:0]              query_x,
  input  logic [YW-1:0]              query_y,
  output logic                       query_wall,
  output logic [NUM_PLAYERS-1:0]     query_head,
  output logic [2:0]                 state,
  output logic [NUM_PLAYERS-1:0]     crashed,
  output logic [4*NUM_PLAYERS-1:0]   score,
  output logic [NUM_PLAYERS-1:0]     winner
);

  state_e                 state_q;
  logic [YW-1:0]          row_q;
  logic [XW-1:0]          head_x_q  [NUM_PLAYERS];
  logic [YW-1:0]          head_y_q  [NUM_PLAYERS];
  logic [1:0]             heading_q [NUM_PLAYERS];
  logic [1:0]             pending_q [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] crashed_q;
  logic [NUM_PLAYERS-1:0] winner_q;
  logic [3:0]             score_q   [NUM_PLAYERS];
  logic [GRID_W-1:0]      grid_q    [GRID_H];
  logic                   query_wall_q;
  logic [NUM_PLAYERS-1:0] query_head_q;

  logic                   tick;
  logic [XW-1:0]          next_x      [NUM_PLAYERS];
  logic [YW-1:0]          next_y      [NUM_PLAYERS];
  logic [1:0]             ref_heading [NUM_PLAYERS];
  logic [3:0]             score_d     [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] crash_now;
  logic [NUM_PLAYERS-1:0] crashed_d;
  logic [NUM_PLAYERS-1:0] winner_d;
  logic [2:0]             alive_cnt;
  logic                   round_end;
  logic                   match_won;
  logic [GRID_W-1:0]      clear_row;
  logic                   in_range;

  lightbike_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == StDriving),
    .tick   (tick)
  );

  always_comb begin
    crash_now = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      next_x[k] = head_x_q[k];
      next_y[k] = head_y_q[k];
      case (pending_q[k])
        DirUp:    next_y[k] = head_y_q[k] - YW'(1);
        DirRight: next_x[k] = head_x_q[k] + XW'(1);
        DirDown:  next_y[k] = head_y_q[k] + YW'(1);
        DirLeft:  next_x[k] = head_x_q[k] - XW'(1);
        default:  next_x[k] = head_x_q[k];
      endcase
      // A request landing on the tick cycle is judged against the heading it will follow.
      ref_heading[k] = tick ? pending_q[k] : heading_q[k];
    end

    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      if (!crashed_q[k]) begin
        if (grid_q[next_y[k]][next_x[k]]) crash_now[k] = 1'b1;
        for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
          if (!crashed_q[j]) begin
            if (next_x[k] == head_x_q[j] && next_y[k] == head_y_q[j]) crash_now[k] = 1'b1;
            if (j != k && next_x[k] == next_x[j] && next_y[k] == next_y[j]) begin
              crash_now[k] = 1'b1;
            end
          end
        end
      end
    end

    crashed_d = crashed_q | crash_now;
    alive_cnt = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      if (!crashed_d[k]) alive_cnt = alive_cnt + 3'd1;
    end
    round_end = tick && (alive_cnt <= 3'd1);

    match_won = 1'b0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      score_d[k] = score_q[k];
      if (alive_cnt == 3'd1 && !crashed_d[k] && score_q[k] != 4'hf) begin
        score_d[k] = score_q[k] + 4'd1;
      end
      winner_d[k] = (score_d[k] == 4'(WIN_SCORE));
      match_won   = match_won | winner_d[k];
    end

    clear_row = '0;
    clear_row[0] = 1'b1;
    clear_row[GRID_W-1] = 1'b1;
    if (row_q == '0 || row_q == YW'(GRID_H - 1)) clear_row = '1;

    in_range = (32'(query_x) < GRID_W) && (32'(query_y) < GRID_H);
  end

  // Grid has no reset: CLEAR always rebuilds it before any move reads it.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      grid_q[row_q] <= clear_row;
    end else if (state_q == StDriving && tick) begin
      for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
        if (!crashed_q[k]) grid_q[head_y_q[k]][head_x_q[k]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      query_wall_q <= 1'b0;
      query_head_q <= '0;
    end else begin
      query_wall_q <= in_range && grid_q[query_y][query_x];
      for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
        query_head_q[k] <= in_range && query_x == head_x_q[k] && query_y == head_y_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      row_q     <= '0;
      crashed_q <= '0;
      winner_q  <= '0;
      for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
        head_x_q[k]  <= '0;
        head_y_q[k]  <= '0;
        heading_q[k] <= DirUp;
        pending_q[k] <= DirUp;
        score_q[k]   <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StClear;
            row_q   <= '0;
          end
        end
        StClear: begin
          for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
            head_x_q[k]  <= XW'((k + 1) * GRID_W / (NUM_PLAYERS + 1));
            head_y_q[k]  <= YW'(GRID_H / 2);
            heading_q[k] <= (k % 2 == 0) ? DirRight : DirLeft;
            pending_q[k] <= (k % 2 == 0) ? DirRight : DirLeft;
          end
          crashed_q <= '0;
          row_q     <= row_q + YW'(1);
          if (row_q == YW'(GRID_H - 1)) begin
            row_q   <= '0;
            state_q <= StDriving;
          end
        end
        StDriving: begin
          for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
            if (dir_valid[k] && !is_reversal(dir[2*k +: 2], ref_heading[k])) begin
              pending_q[k] <= dir[2*k +: 2];
            end
          end
          if (tick) begin
            for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
              heading_q[k] <= pending_q[k];
              if (!crashed_d[k]) begin
                head_x_q[k] <= next_x[k];
                head_y_q[k] <= next_y[k];
              end
            end
            crashed_q <= crashed_d;
            if (round_end) begin
              for (int unsigned k = 0; k < NUM_PLAYERS; k++) score_q[k] <= score_d[k];
              if (match_won) begin
                state_q  <= StDone;
                winner_q <= winner_d;
              end else begin
                state_q <= StCollision;
              end
            end
          end
        end
        StCollision: begin
          if (start) begin
            state_q <= StClear;
            row_q   <= '0;
          end
        end
        StDone: begin
          if (start) begin
            state_q  <= StIdle;
            winner_q <= '0;
            for (int unsigned k = 0; k < NUM_PLAYERS; k++) score_q[k] <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign state      = state_q;
  assign crashed    = crashed_q;
  assign winner     = winner_q;
  assign query_wall = query_wall_q;
  assign query_head = query_head_q;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
    assign score[4*g +: 4] = score_q[g];
  end

endmodule

// File: tb/tb_lightbike_engine.sv
// Bench for lightbike_engine: game-level reference model compared every cycle,
// plus directed rounds with hand-computed expectations.
module tb_lightbike_engine;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int NP = 2;
  localparam int TD = 4;
  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dir_valid = '0;
  logic [3:0] dir = '0;
  logic [3:0] qx = '0;
  logic [3:0] qy = '0;
  logic       query_wall;
  logic [1:0] query_head;
  logic [2:0] state;
  logic [1:0] crashed;
  logic [7:0] score;
  logic [1:0] winner;

  lightbike_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .query_x    (qx),
    .query_y    (qy),
    .query_wall (query_wall),
    .query_head (query_head),
    .state      (state),
    .crashed    (crashed),
    .score      (score),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (game rules, state codes 0..4) ----------------
  int       m_state, m_row, m_tick;
  bit       m_grid [H][W];
  int       hx [NP];
  int       hy [NP];
  int       hd [NP];
  int       pd [NP];
  int       m_score [NP];
  bit [1:0] m_crashed, m_winner;
  bit       m_grid_ok, q_ok, q_wall_exp;
  bit [1:0] q_head_exp;

  task automatic m_reset();
    m_state = 0; m_row = 0; m_tick = 0;
    m_crashed = '0; m_winner = '0;
    m_grid_ok = 1'b0; q_ok = 1'b1; q_wall_exp = 1'b0; q_head_exp = '0;
    for (int k = 0; k < NP; k++) begin
      hx[k] = 0; hy[k] = 0; hd[k] = 0; pd[k] = 0; m_score[k] = 0;
    end
  endtask

  task automatic m_move();
    int nx [NP];
    int ny [NP];
    bit hit [NP];
    int alive, surv;
    for (int k = 0; k < NP; k++) begin
      nx[k] = hx[k]; ny[k] = hy[k]; hit[k] = 1'b0;
      if (!m_crashed[k]) begin
        hd[k] = pd[k];
        case (pd[k])
          0: ny[k] = hy[k] - 1;
          1: nx[k] = hx[k] + 1;
          2: ny[k] = hy[k] + 1;
          default: nx[k] = hx[k] - 1;
        endcase
      end
    end
    for (int k = 0; k < NP; k++) begin
      if (!m_crashed[k]) begin
        if (m_grid[ny[k]][nx[k]]) hit[k] = 1'b1;
        for (int j = 0; j < NP; j++) begin
          if (!m_crashed[j]) begin
            if (hx[j] == nx[k] && hy[j] == ny[k]) hit[k] = 1'b1;
            if (j != k && nx[j] == nx[k] && ny[j] == ny[k]) hit[k] = 1'b1;
          end
        end
      end
    end
    for (int k = 0; k < NP; k++) begin
      if (!m_crashed[k]) begin
        m_grid[hy[k]][hx[k]] = 1'b1;
        if (hit[k]) m_crashed[k] = 1'b1;
        else begin hx[k] = nx[k]; hy[k] = ny[k]; end
      end
    end
    alive = 0; surv = 0;
    for (int k = 0; k < NP; k++) if (!m_crashed[k]) begin alive++; surv = k; end
    if (alive <= 1) begin
      if (alive == 1 && m_score[surv] < 15) m_score[surv]++;
      m_state = 3;
      for (int k = 0; k < NP; k++) begin
        if (m_score[k] == WS) begin m_state = 4; m_winner[k] = 1'b1; end
      end
    end
  endtask

  task automatic m_step();
    bit tk;
    int d;
    q_ok = m_grid_ok;
    q_wall_exp = m_grid[qy][qx];
    for (int k = 0; k < NP; k++) q_head_exp[k] = (hx[k] == int'(qx) && hy[k] == int'(qy));
    case (m_state)
      0: if (start) begin m_state = 1; m_row = 0; end
      1: begin
        for (int x = 0; x < W; x++) begin
          m_grid[m_row][x] = (m_row == 0 || m_row == H - 1 || x == 0 || x == W - 1);
        end
        for (int k = 0; k < NP; k++) begin
          hx[k] = (k + 1) * W / (NP + 1);
          hy[k] = H / 2;
          hd[k] = (k % 2 == 0) ? 1 : 3;
          pd[k] = hd[k];
        end
        m_crashed = '0;
        m_row++;
        if (m_row == H) begin m_state = 2; m_tick = 0; m_grid_ok = 1'b1; end
      end
      2: begin
        tk = (m_tick == TD - 1);
        m_tick = tk ? 0 : m_tick + 1;
        if (tk) m_move();
        if (m_state == 2) begin
          for (int k = 0; k < NP; k++) begin
            if (dir_valid[k]) begin
              d = int'(dir[2*k +: 2]);
              if ((d ^ hd[k]) != 2) pd[k] = d;
            end
          end
        end
      end
      3: if (start) begin m_state = 1; m_row = 0; end
      4: if (start) begin
        m_state = 0; m_winner = '0;
        for (int k = 0; k < NP; k++) m_score[k] = 0;
      end
      default: m_state = 0;
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("model_state", 32'(state), 32'(m_state));
        check("model_crashed", 32'(crashed), 32'(m_crashed));
        check("model_score", 32'(score), 32'((m_score[1] << 4) | m_score[0]));
        check("model_winner", 32'(winner), 32'(m_winner));
        if (q_ok) begin
          check("model_query_wall", 32'(query_wall), 32'(q_wall_exp));
          check("model_query_head", 32'(query_head), 32'(q_head_exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int max);
    int n = 0;
    while (state != st && n < max) begin @(negedge clk); n++; end
    check("wait_state", 32'(state), 32'(st));
  endtask

  task automatic wait_leave_driving(input int max);
    int n = 0;
    while (state == 3'd2 && n < max) begin @(negedge clk); n++; end
    check("round_ends", 32'(state != 3'd2), 32'd1);
  endtask

  task automatic up_round();
    pulse_start();
    wait_state(3'd2, 40);
    dir_valid = 2'b01; dir = 4'b0000;
    @(negedge clk);
    dir_valid = 2'b00;
    wait_leave_driving(100);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_crashed", 32'(crashed), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_query_wall", 32'(query_wall), 32'd0);
    check("rst_query_head", 32'(query_head), 32'd0);
    reset = 1'b0;

    // Straight-line head-on round, with cell lookups.
    pulse_start();
    wait_state(3'd2, 40);
    qx = 4'd0; qy = 4'd3;
    @(negedge clk); check("q_border_0_3", 32'(query_wall), 32'd1);
    qx = 4'd3; qy = 4'd3;
    @(negedge clk); check("q_interior_3_3", 32'(query_wall), 32'd0);
    qx = 4'd5; qy = 4'd8;
    @(negedge clk); check("q_head_5_8", 32'(query_head), 32'd1);
    qx = 4'd6;
    @(negedge clk);
    @(negedge clk); check("q_head_6_8_tick1", 32'(query_head), 32'd1);
    qx = 4'd9;
    @(negedge clk); check("q_head_9_8_tick1", 32'(query_head), 32'd2);
    wait_leave_driving(100);
    check("draw_state", 32'(state), 32'd3);
    check("draw_crashed", 32'(crashed), 32'd3);
    check("draw_score", 32'(score), 32'h00);

    // Player 0 turns up; player 1 runs into its trail.
    up_round();
    check("up_state", 32'(state), 32'd3);
    check("up_crashed", 32'(crashed), 32'd2);
    check("up_score", 32'(score), 32'h01);
    qx = 4'd5; qy = 4'd8;
    @(negedge clk); check("q_trail_5_8", 32'(query_wall), 32'd1);

    // Reversal request is dropped: plays out as a draw.
    pulse_start();
    wait_state(3'd2, 40);
    dir_valid = 2'b01; dir = 4'b0011;
    @(negedge clk);
    dir_valid = 2'b00;
    wait_leave_driving(100);
    check("rev_state", 32'(state), 32'd3);
    check("rev_crashed", 32'(crashed), 32'd3);
    check("rev_score", 32'(score), 32'h01);

    up_round();
    check("up2_score", 32'(score), 32'h02);

    // Asynchronous reset between edges in the middle of a round.
    pulse_start();
    wait_state(3'd2, 40);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_score", 32'(score), 32'd0);
    check("async_rst_crashed", 32'(crashed), 32'd0);
    check("async_rst_query", 32'({query_wall, query_head}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three wins end the match.
    up_round();
    up_round();
    check("match_mid_state", 32'(state), 32'd3);
    up_round();
    check("match_state", 32'(state), 32'd4);
    check("match_winner", 32'(winner), 32'd1);
    check("match_score", 32'(score), 32'h03);
    pulse_start();
    check("idle_state", 32'(state), 32'd0);
    check("idle_score", 32'(score), 32'd0);
    check("idle_winner", 32'(winner), 32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
